// File: rtl/whack_scorer_pkg.sv
// Shared definitions for the whack-a-mole scorer and the display block:
// FSM encoding, hole count, default counter sizing and a one-hot helper.
package whack_scorer_pkg;

  localparam int NUM_HOLES    = 9;
  localparam int SCORE_W_DEF  = 8;
  localparam int MISS_MAX_DEF = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LIT,
    ST_SCORED,
    ST_OVER
  } state_t;

  // Isolate the lowest set bit (v & -v).
  function automatic logic [NUM_HOLES-1:0] lowest_bit(input logic [NUM_HOLES-1:0] v);
    return v & (~v + {{(NUM_HOLES-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/whack_scorer_button_conditioner.sv
// One button: two-flop synchronizer, optional debouncer
// (WHACK_SCORER_DEBOUNCE_EN), then a registered rising-edge press pulse.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic sync1, sync2, lvl, lvl_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef WHACK_SCORER_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          db;

  // Level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (sync2 == db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      db  <= sync2;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign lvl = db;
`else
  assign lvl = sync2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lvl_q <= 1'b0;
      press <= 1'b0;
    end else begin
      lvl_q <= lvl;
      press <= lvl & ~lvl_q;
    end
  end

endmodule

// File: rtl/whack_scorer.sv
// Judges lit moles as hit/missed, keeps saturating score and miss counters.
// Optional button debouncing via WHACK_SCORER_DEBOUNCE_EN.
module whack_scorer
  import whack_scorer_pkg::*;
#(
  parameter int SCORE_W         = SCORE_W_DEF,
  parameter int MISS_MAX        = MISS_MAX_DEF,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_HOLES-1:0] lights,
  input  logic [NUM_HOLES-1:0] buttons,
  output logic [SCORE_W-1:0]   score,
  output logic [3:0]           misses,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic                 wrong_pulse,
  output logic                 playing,
  output logic                 game_over
);

  if (MISS_MAX < 1 || MISS_MAX > 15) begin : g_bad_cfg
    $error("MISS_MAX must be in 1..15");
  end

  localparam logic [3:0] MISS_LIM = 4'(MISS_MAX);

  logic [NUM_HOLES-1:0] press, lights_q, rise, fall;
  logic [NUM_HOLES-1:0] target_q, target_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [3:0]           misses_q, misses_d;
  logic                 hit_d, miss_d, wrong_d;
  state_t               state_q, state_d;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn [NUM_HOLES-1:0] (
    .clk   (clk),
    .reset (reset),
    .btn   (buttons),
    .press (press)
  );

  assign rise = lights & ~lights_q;
  assign fall = lights_q & ~lights;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    score_d  = score_q;
    misses_d = misses_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    wrong_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          score_d  = '0;
          misses_d = '0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (|rise) begin
          target_d = lowest_bit(rise);
          state_d  = ST_LIT;
        end
      end
      ST_LIT: begin
        if (|(press & target_q)) begin
          hit_d = 1'b1;
          if (score_q != '1) score_d = score_q + SCORE_W'(1);
          // A fall coinciding with the hit is consumed here, not in SCORED.
          state_d = (|(fall & target_q)) ? ST_WAIT : ST_SCORED;
        end else if (|press) begin
          wrong_d = 1'b1;
          if (score_q != '0) score_d = score_q - SCORE_W'(1);
        end else if (|(fall & target_q)) begin
          miss_d   = 1'b1;
          misses_d = misses_q + 4'd1;
          state_d  = (misses_d == MISS_LIM) ? ST_OVER : ST_WAIT;
        end
      end
      ST_SCORED: begin
        if (|(fall & target_q)) state_d = ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      lights_q    <= '0;
      score_q     <= '0;
      misses_q    <= '0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      wrong_pulse <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      lights_q    <= lights;
      score_q     <= score_d;
      misses_q    <= misses_d;
      hit_pulse   <= hit_d;
      miss_pulse  <= miss_d;
      wrong_pulse <= wrong_d;
    end
  end

  assign score     = score_q;
  assign misses    = misses_q;
  assign playing   = (state_q == ST_WAIT) || (state_q == ST_LIT) || (state_q == ST_SCORED);
  assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_whack_scorer.sv
// Scoreboard bench: stimulus pushes expected pulses, a negedge monitor pops and checks.
module tb_whack_scorer;

`ifdef WHACK_SCORER_DEBOUNCE_EN
  localparam int HOLD = 20;
  localparam int LAT  = 19;
`else
  localparam int HOLD = 2;
  localparam int LAT  = 3;
`endif

  localparam logic [2:0] K_HIT = 3'b100, K_MISS = 3'b010, K_WRONG = 3'b001;

  typedef struct {
    logic [2:0] kind;
    int         score;
    int         misses;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [8:0] lights = '0;
  logic [8:0] buttons = '0;
  logic [7:0] score;
  logic [3:0] misses;
  logic       hit_pulse, miss_pulse, wrong_pulse, playing, game_over;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  whack_scorer #(.SCORE_W(8), .MISS_MAX(5), .DEBOUNCE_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .start       (start),
    .lights      (lights),
    .buttons     (buttons),
    .score       (score),
    .misses      (misses),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .wrong_pulse (wrong_pulse),
    .playing     (playing),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (hit_pulse || miss_pulse || wrong_pulse)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got hit/miss/wrong=%b%b%b expected none",
                 hit_pulse, miss_pulse, wrong_pulse);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind", int'({hit_pulse, miss_pulse, wrong_pulse}), int'(e.kind));
        chk("pulse_score", int'(score), e.score);
        chk("pulse_misses", int'(misses), e.misses);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] k, input int s, input int m);
    exp_t e;
    e.kind = k; e.score = s; e.misses = m;
    q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; lights = '0; buttons = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
  endtask

  task automatic press_btn(input int idx);
    buttons[idx] = 1'b1;
    tick(HOLD);
    buttons = '0;
    tick(LAT + 2);
  endtask

  task automatic do_hit(input int idx, input int pre, input int s, input int m);
    lights = '0;
    lights[idx] = 1'b1;
    tick(pre);
    push(K_HIT, s, m);
    press_btn(idx);
    lights = '0;
    tick(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("reset_score", score, 0);
    chk("reset_misses", misses, 0);
    chk("reset_playing", playing, 0);
    chk("reset_game_over", game_over, 0);
    chk("reset_pulses", {hit_pulse, miss_pulse, wrong_pulse}, 0);

    // Basic hit on hole 4, pressed 5 cycles after the light.
    do_start();
    chk("start_playing", playing, 1);
    do_hit(4, 5, 1, 0);
    chk("hit_score", score, 1);
    chk("hit_misses", misses, 0);
    chk("hit_playing", playing, 1);

    // Reset mid-game clears everything immediately.
    rst_n = 1'b0;
    #1;
    chk("midreset_score", score, 0);
    chk("midreset_playing", playing, 0);
    do_reset();

    // Wrong press at zero score, then the mole escapes.
    do_start();
    lights = 9'h002;
    tick(3);
    push(K_WRONG, 0, 0);
    press_btn(7);
    push(K_MISS, 0, 1);
    lights = '0;
    tick(3);
    chk("wrong_score", score, 0);
    chk("wrong_misses", misses, 1);

    // Five misses end the game.
    do_reset();
    do_start();
    for (int i = 0; i < 5; i++) begin
      lights = 9'(1 << i);
      tick(3);
      push(K_MISS, 0, i + 1);
      lights = '0;
      tick(3);
    end
    chk("over_misses", misses, 5);
    chk("over_game_over", game_over, 1);
    chk("over_playing", playing, 0);
    lights = 9'h008;
    tick(2);
    press_btn(3);
    lights = '0;
    tick(3);
    chk("over_frozen_score", score, 0);
    chk("over_frozen_misses", misses, 5);
    chk("over_frozen_flag", game_over, 1);
    do_start();
    chk("restart_misses", misses, 0);
    chk("restart_score", score, 0);
    chk("restart_playing", playing, 1);
    chk("restart_game_over", game_over, 0);

    // Correct press lands in the same cycle the target light falls.
    lights = 9'h100;
    tick(3);
    push(K_HIT, 1, 0);
    buttons[8] = 1'b1;
    tick(LAT);
    lights = '0;
    buttons = '0;
    tick(LAT + 4);
    chk("fallhit_score", score, 1);
    do_hit(0, 2, 2, 0);
    chk("fallhit_back_in_wait", score, 2);

    // Saturation at 255.
    do_reset();
    do_start();
    for (int i = 0; i < 256; i++) do_hit(i % 9, 2, (i < 255) ? i + 1 : 255, 0);
    chk("sat_score", score, 255);
    chk("sat_misses", misses, 0);

`ifdef WHACK_SCORER_DEBOUNCE_EN
    // A 3-cycle glitch never becomes a press, so the mole is missed.
    lights = 9'h001;
    tick(2);
    buttons[0] = 1'b1;
    tick(3);
    buttons = '0;
    tick(30);
    push(K_MISS, 255, 1);
    lights = '0;
    tick(3);
    // A 200-cycle hold produces exactly one hit.
    lights = 9'h004;
    tick(2);
    push(K_HIT, 255, 1);
    buttons[2] = 1'b1;
    tick(200);
    buttons = '0;
    tick(25);
    lights = '0;
    tick(3);
    chk("db_misses", misses, 1);
`endif

    tick(5);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
